// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers (shift-add multiply, restoring divide).
// Optional MULDIV_DZ_EN: early-out on divide by zero with a div_zero pulse.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MULDIV_DZ_EN
  ,
  output logic             div_zero
`endif
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc, acc_nx;
  logic [WIDTH-1:0]   b_reg, a_abs, b_abs, res_hi, res_lo;
  logic [WIDTH:0]     mul_sum, rem, diff;
  logic               is_div, neg_q, neg_r, start_md, sgn;
`ifdef MULDIV_DZ_EN
  logic               dz_flag;
`endif

  assign start_md = start && !op[2];
  assign sgn      = !op[0];
  assign a_abs    = (sgn && A[WIDTH-1]) ? -A : A;
  assign b_abs    = (sgn && B[WIDTH-1]) ? -B : B;
  assign busy     = (state != IDLE);

  // acc = {upper, lower}: product accumulates from the top, divide keeps {remainder, quotient}
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_reg} : '0);
    rem     = acc[2*WIDTH-1:WIDTH-1];
    diff    = rem - {1'b0, b_reg};
    if (!is_div)       acc_nx = {mul_sum, acc[WIDTH-1:1]};
    else if (!diff[WIDTH]) acc_nx = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else               acc_nx = {rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    if (is_div) begin
      res_lo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      res_hi = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end else begin
      {res_hi, res_lo} = neg_q ? -acc : acc;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start_md) begin
        state_nx = CALC;
`ifdef MULDIV_DZ_EN
        if (op[1] && B == '0) state_nx = FIX;
`endif
      end
      CALC: if (count == CW'(WIDTH - 1)) state_nx = FIX;
      FIX:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      acc    <= '0;
      b_reg  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
`ifdef MULDIV_DZ_EN
      dz_flag  <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MULDIV_DZ_EN
      div_zero <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start_md) begin
            count  <= '0;
            acc    <= {{WIDTH{1'b0}}, a_abs};
            b_reg  <= b_abs;
            is_div <= op[1];
            neg_q  <= sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_r  <= sgn && A[WIDTH-1];
`ifdef MULDIV_DZ_EN
            dz_flag <= op[1] && B == '0;
            // raw dividend goes straight to HI on the early-out path
            if (op[1] && B == '0) acc <= {{WIDTH{1'b0}}, A};
`endif
          end else if (start && op == 3'b100) begin
            hi <= A;
          end else if (start && op == 3'b101) begin
            lo <= A;
          end
        end
        CALC: begin
          acc   <= acc_nx;
          count <= count + 1'b1;
        end
        FIX: begin
          done <= 1'b1;
`ifdef MULDIV_DZ_EN
          div_zero <= dz_flag;
          if (dz_flag) begin
            hi <= acc[WIDTH-1:0];
            lo <= '1;
          end else
`endif
          begin
            hi <= res_hi;
            lo <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO queued at issue, popped on done.
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b111;
  logic [31:0] A = '0, B = '0;
  logic        busy, done;
  logic [31:0] hi, lo;
`ifdef MULDIV_DZ_EN
  logic        div_zero;
`endif
  int          total = 0, bad = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
`ifdef MULDIV_DZ_EN
    , .div_zero(div_zero)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference {hi,lo} from native integer arithmetic
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int     q, r;
    case (o)
      3'd0: begin p = longint'($signed(a)) * longint'($signed(b)); return p; end
      3'd1: return {32'b0, a} * {32'b0, b};
      3'd2: begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit push);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    if (push) sb_q.push_back(model(o, a, b));
    @(negedge clk);
    start = 1'b0; op = 3'b111; A = $urandom; B = $urandom;
  endtask

  // counts edges after the sampling edge until done; optional MTLO poke at cycle inj
  task automatic wait_done(input string tag, input int exp_lat, input int exp_busy, input int inj, input bit exp_dz);
    int          n = 0;
    int          bcnt;
    bit          stable = 1'b1;
    logic [31:0] h0 = hi, l0 = lo;
    logic [63:0] e;
    bcnt = int'(busy);
    while (!done && n < 200) begin
      @(posedge clk); #1; n++;
      if (n == inj) begin start = 1'b1; op = 3'b101; A = 32'h1234; end
      else if (n == inj + 1) start = 1'b0;
      if (busy) bcnt++;
      if (!done && (hi !== h0 || lo !== l0)) stable = 1'b0;
    end
    chk({tag, "_lat"}, n, exp_lat);
    if (exp_busy >= 0) chk({tag, "_busy"}, bcnt, exp_busy);
    chk({tag, "_hold"}, stable, 1);
`ifdef MULDIV_DZ_EN
    chk({tag, "_dz"}, div_zero, exp_dz);
`else
    if (exp_dz) chk({tag, "_dz_len"}, n, 32'd33);
`endif
    if (sb_q.size() == 0) chk({tag, "_sb_empty"}, 1, 0);
    else begin
      e = sb_q.pop_front();
      chk({tag, "_hi"}, hi, e[63:32]);
      chk({tag, "_lo"}, lo, e[31:0]);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [2:0]  o;
    logic [31:0] a, b;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    @(negedge clk); rst_n = 1'b1;

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    wait_done("multu_max", 33, 33, 0, 0);
    chk("multu_max_hi_c", hi, 32'hFFFF_FFFE);
    chk("multu_max_lo_c", lo, 32'h0000_0001);

    issue(3'd0, 32'hFFFF_FFF9, 32'd6, 1);
    wait_done("mult_neg", 33, 33, 0, 0);
    chk("mult_neg_lo_c", lo, 32'hFFFF_FFD6);

    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1);
    wait_done("div_neg", 33, 33, 0, 0);
    chk("div_neg_lo_c", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi_c", hi, 32'hFFFF_FFFF);

    issue(3'd3, 32'd100, 32'd7, 1);
    wait_done("divu", 33, 33, 0, 0);
    chk("divu_lo_c", lo, 32'd14);

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    wait_done("div_ovf", 33, 33, 0, 0);

    for (int i = 0; i < 12; i++) begin
      o = 3'(i % 4);
      a = $urandom;
      b = (i % 3 == 0) ? $urandom_range(1, 300) : $urandom;
      if (b == 0) b = 1;
      issue(o, a, b, 1);
      wait_done($sformatf("rnd%0d", i), 33, 33, 0, 0);
    end

    // MTLO while busy must be dropped
    issue(3'd1, 32'd3, 32'd5, 1);
    wait_done("busy_blk", 33, 33, 10, 0);
    chk("busy_blk_lo_c", lo, 32'd15);

    // idle MTHI/MTLO and NOP
    @(negedge clk); start = 1'b1; op = 3'b100; A = 32'h5A5A_0001;
    @(posedge clk); #1;
    chk("mthi_hi", hi, 32'h5A5A_0001);
    chk("mthi_busy", busy, 0);
    @(negedge clk); op = 3'b101; A = 32'h0000_BEEF;
    @(posedge clk); #1;
    chk("mtlo_lo", lo, 32'h0000_BEEF);
    chk("mtlo_hi", hi, 32'h5A5A_0001);
    @(negedge clk); op = 3'b110; A = 32'h1111_1111;
    @(posedge clk); #1;
    chk("nop_busy", busy, 0);
    chk("nop_hi", hi, 32'h5A5A_0001);
    @(posedge clk); #1;
    chk("nop_done", done, 0);
    @(negedge clk); start = 1'b0;

    // reset mid-operation
    issue(3'd3, 32'd1000, 32'd7, 0);
    repeat (19) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    chk("rmid_busy", busy, 0);
    chk("rmid_hi", hi, 0);
    chk("rmid_lo", lo, 0);
    repeat (3) @(posedge clk);
    #1; chk("rmid_done", done, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); start = 1'b1; op = 3'b100; A = 32'h0000_ABCD;
    @(posedge clk); #1;
    chk("rmid_mthi", hi, 32'h0000_ABCD);
    chk("rmid_mthi_busy", busy, 0);
    @(negedge clk); start = 1'b0;

    // divide by zero
    issue(3'd3, 32'd9, 32'd0, 1);
`ifdef MULDIV_DZ_EN
    wait_done("divu_z", 1, 1, 0, 1);
`else
    wait_done("divu_z", 33, 33, 0, 1);
`endif
    chk("divu_z_lo_c", lo, 32'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
